axil_uart_tx_ctrl: RTL and testbench
====================================

AXIL_UART_TX_CTRL -- requirements
Module: axil_uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, TX byte FIFO entries, power of two, >= 2.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports awvalid in 1, awready out 1, awaddr in 32: AXI4-Lite write address.
REQ-006 SHALL have ports wvalid in 1, wready out 1, wdata in 32, wstrb in 4: AXI4-Lite write data.
REQ-007 SHALL have ports bvalid out 1, bready in 1, bresp out 2: AXI4-Lite write response.
REQ-008 SHALL have ports arvalid in 1, arready out 1, araddr in 32: AXI4-Lite read address.
REQ-009 SHALL have ports rvalid out 1, rready in 1, rdata out 32, rresp out 2: AXI4-Lite read data.
REQ-010 SHALL have port tx  out  1  UART serial output, idle high.

Function
REQ-011 SHALL decode awaddr[3:2]/araddr[3:2] only: 0 = TXDATA (write-only), 1 = STATUS (read-only), others reserved.
REQ-012 SHALL assert awready and wready together for exactly one cycle when awvalid && wvalid && !bvalid; no AW-only or W-only acceptance.
REQ-013 SHALL, on write accept, raise bvalid next cycle, hold it and bresp until bready; only one write outstanding.
REQ-014 SHALL push wdata[7:0] into FIFO on TXDATA write with wstrb[0]=1 and FIFO not full; bresp=2'b00.
REQ-015 SHALL drop the byte and return bresp=2'b10 on TXDATA write while full; fullness sampled before a same-cycle pop.
REQ-016 SHALL ignore writes to STATUS/reserved or with wstrb[0]=0, bresp=2'b00.
REQ-017 SHALL assert arready one cycle when arvalid && !rvalid; rvalid next cycle, held with rdata/rresp until rready.
REQ-018 SHALL return STATUS rdata = {29'b0, busy, empty, full}, sampled at AR accept; TXDATA/reserved read 0; rresp always 2'b00.
REQ-019 SHALL run TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, each state bit lasting CLK_DIV cycles.
REQ-020 SHALL leave IDLE on the cycle after FIFO non-empty, popping head byte in that transition; tx=0 in START, data bit in DATA, 1 in STOP/IDLE.
REQ-021 SHALL, after STOP, go directly to START if FIFO non-empty (back-to-back frames, no idle bit).
REQ-022 SHALL define busy = FSM not IDLE; empty/full from pointer compare with one extra wrap bit; pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL allow push and pop in the same cycle when not full; count unchanged.
REQ-024 SHALL drive tx from a register (no combinational glitches).

Reset
REQ-025 SHALL on rst_n low immediately force awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rdata=0, rresp=0, tx=1, FSM=IDLE, FIFO empty, bit counters 0.
REQ-026 SHALL abandon a frame in progress on reset mid-frame; tx returns high with no completion of the frame.

Configuration
REQ-027 SHALL, with macro AXIL_UART_TX_SIM_PRINT_EN defined, $write each byte as %c to the simulator console when it is popped into START; without it, no simulation output and identical RTL behaviour.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-028 SHALL: write 0x41 to 0x10000000 -> bresp 00; tx low 4 cycles, then 1,0,0,0,0,0,1,0 each 4 cycles, then high 4 cycles.
REQ-029 SHALL: write 0x55,0xAA back-to-back -> two frames with no idle gap; STATUS busy=1 throughout, then 0x2 after.
REQ-030 SHALL: 6 writes with tx stalled by the first frame -> 5 accepted (1 in flight + 4 FIFO), 6th bresp 10, STATUS full=1.
REQ-031 SHALL: AW valid 3 cycles before W valid -> awready/wready both rise only in the cycle W arrives; bready held low 5 cycles -> bvalid stays high.
REQ-032 SHALL: rst_n low mid-DATA of a frame -> tx=1 same cycle, STATUS reads 0x2 after release, no further frame.

Source files
------------

// File: rtl/axil_uart_tx_ctrl.sv
// AXI4-Lite controlled UART transmitter with a byte FIFO.
// Register map (addr[3:2]): 0 = TXDATA (write-only), 1 = STATUS (read-only,
// {29'b0, busy, empty, full}), 2/3 reserved.
// Define AXIL_UART_TX_SIM_PRINT_EN to echo each transmitted byte to the
// simulator console when it is popped into the START state.
module axil_uart_tx_ctrl #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] div_cnt;
  logic          div_end;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    tx_byte;
  logic          tx_next;
  logic          pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, busy;

  logic          out_of_reset;
  logic          wr_accept, wr_is_tx, push, wr_drop;
  logic [31:0]   status_word;

  // Sink for address/data bits that the register map never looks at.
  logic          unused_bits;
  assign unused_bits = &{1'b0, awaddr[31:4], awaddr[1:0], araddr[31:4],
                         araddr[1:0], wdata[31:8], wstrb[3:1]};

  // Registered enable keeps the ready outputs low while reset is asserted
  // without routing rst_n into datapath logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_of_reset <= 1'b0;
    else        out_of_reset <= 1'b1;
  end

  assign awready   = out_of_reset && awvalid && wvalid && !bvalid;
  assign wready    = awready;
  assign wr_accept = awready;
  assign wr_is_tx  = (awaddr[3:2] == 2'b00) && wstrb[0];
  assign push      = wr_accept && wr_is_tx && !full;
  assign wr_drop   = wr_accept && wr_is_tx && full;

  assign arready   = out_of_reset && arvalid && !rvalid;
  assign rresp     = 2'b00;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy        = (state != ST_IDLE);
  assign status_word = {29'b0, busy, empty, full};

  // Write response: one outstanding write, response held until bready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end else if (wr_accept) begin
      bvalid <= 1'b1;
      bresp  <= wr_drop ? 2'b10 : 2'b00;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
  end

  // Read data: STATUS captured at address accept, everything else reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (arready) begin
      rvalid <= 1'b1;
      rdata  <= (araddr[3:2] == 2'b01) ? status_word : '0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata[7:0];
  end

  // FIFO pointers with an extra wrap bit for full/empty discrimination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign div_end = (div_cnt == DIV_LAST);

  // TX state register, bit-period divider, bit index, frame byte and line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      tx_byte <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      bit_idx <= bit_next;
      tx      <= tx_next;
      if (state == ST_IDLE || div_end) div_cnt <= '0;
      else                             div_cnt <= div_cnt + 1'b1;
      if (pop) begin
        tx_byte <= mem[rd_ptr[AW-1:0]];
`ifdef AXIL_UART_TX_SIM_PRINT_EN
        $write("%c", mem[rd_ptr[AW-1:0]]);
`endif
      end
    end
  end

  // TX next-state, FIFO pop and the line level for the next cycle.
  always_comb begin
    state_next = state;
    bit_next   = bit_idx;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_next = ST_START;
          pop        = 1'b1;
        end
      end
      ST_START: begin
        if (div_end) begin
          state_next = ST_DATA;
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (div_end) begin
          if (bit_idx == 3'd7) state_next = ST_STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (div_end) begin
          if (!empty) begin
            state_next = ST_START;
            pop        = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Line level is computed from the upcoming state so tx is a pure flop.
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = tx_byte[bit_next];
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_axil_uart_tx_ctrl.sv
// Directed self-checking bench for axil_uart_tx_ctrl (CLK_DIV=4, FIFO_DEPTH=4).
module tb_axil_uart_tx_ctrl;

  localparam logic [31:0] A_TX   = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, tx;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  axil_uart_tx_ctrl #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lead,
                           input int b_delay, output logic [1:0] resp);
    int n;
    logic [1:0] held;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge clk);
      check("aw_only_ready", {30'b0, awready, wready}, 32'h0);
      @(posedge clk); #1;
    end
    wvalid = 1'b1;
    @(negedge clk);
    check("aw_w_ready", {30'b0, awready, wready}, 32'h3);
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(awready && wready)) begin
      awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    accept_cyc = cyc;
    check("bvalid_rise", {31'b0, bvalid}, 32'h1);
    held = bresp;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      check("bvalid_hold", {29'b0, bvalid, bresp}, {29'b0, 1'b1, held});
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clear", {31'b0, bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    check("ar_ready", {31'b0, arready}, 32'h1);
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid_rise", {31'b0, rvalid}, 32'h1);
    check("rresp", {30'b0, rresp}, 32'h0);
    data = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_clear", {31'b0, rvalid}, 32'h0);
  endtask

  // Waits up to max_wait falling edges for the start bit, then checks each
  // remaining cycle of the 40-cycle frame (4 cycles per bit).
  task automatic expect_frame(input logic [7:0] b, input int max_wait, output int start_cyc);
    logic found;
    logic expb;
    int k;
    found = 1'b0;
    start_cyc = -1;
    for (int n = 0; n < max_wait; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check($sformatf("frame_%h_start", b), {31'b0, found}, 32'h1);
    if (!found) return;
    start_cyc = cyc;
    for (int j = 1; j < 40; j++) begin
      @(negedge clk);
      k = j / 4;
      if (k == 0)      expb = 1'b0;
      else if (k == 9) expb = 1'b1;
      else             expb = b[k-1];
      check($sformatf("frame_%h_c%0d", b, j), {31'b0, tx}, {31'b0, expb});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r, r1, r2;
    logic [1:0]  resps [6];
    logic [31:0] d;
    logic [7:0]  bytes [6];
    int sc, sc2;
    logic bad;

    bytes[0] = 8'hA1; bytes[1] = 8'h32; bytes[2] = 8'hC3;
    bytes[3] = 8'h54; bytes[4] = 8'hE5; bytes[5] = 8'h76;

    // Reset with valids asserted: readies must stay low.
    rst_n = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bready = 1'b0; rready = 1'b0;
    awaddr = A_TX; wdata = '0; wstrb = 4'hF; araddr = A_STAT;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_ready", {29'b0, awready, wready, arready}, 32'h0);
    check("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
    check("rst_resp", {28'b0, bresp, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst_n = 1'b1;

    // Single byte 0x41 with start latency.
    fork
      axi_write(A_TX, 32'h41, 4'hF, 0, 0, r);
      expect_frame(8'h41, 20, sc);
    join
    check("w41_bresp", {30'b0, r}, 32'h0);
    check("start_latency", sc - accept_cyc, 32'd1);
    @(negedge clk);
    check("idle_after_41", {31'b0, tx}, 32'h1);
    axi_read(A_STAT, d);
    check("status_idle", d, 32'h2);

    // Back-to-back frames, busy throughout.
    fork
      begin
        axi_write(A_TX, 32'h55, 4'hF, 0, 0, r1);
        axi_write(A_TX, 32'hAA, 4'hF, 0, 0, r2);
      end
      begin
        expect_frame(8'h55, 20, sc);
        expect_frame(8'hAA, 1, sc2);
      end
      begin
        repeat (20) @(negedge clk);
        axi_read(A_STAT, d);
        check("busy_mid1", {31'b0, d[2]}, 32'h1);
        repeat (30) @(negedge clk);
        axi_read(A_STAT, d);
        check("busy_mid2", {31'b0, d[2]}, 32'h1);
      end
    join
    check("w55_bresp", {30'b0, r1}, 32'h0);
    check("wAA_bresp", {30'b0, r2}, 32'h0);
    axi_read(A_STAT, d);
    check("status_after_b2b", d, 32'h2);

    // Overflow: one in flight + 4 queued, the sixth is dropped.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          axi_write(A_TX, {24'b0, bytes[i]}, 4'hF, 0, 0, r);
          resps[i] = r;
        end
        axi_read(A_STAT, d);
        check("status_full", d, 32'h5);
      end
      begin
        expect_frame(bytes[0], 20, sc);
        for (int i = 1; i < 5; i++) expect_frame(bytes[i], 1, sc);
      end
    join
    for (int i = 0; i < 5; i++) check($sformatf("ovf_bresp%0d", i), {30'b0, resps[i]}, 32'h0);
    check("ovf_bresp5", {30'b0, resps[5]}, 32'h2);
    axi_read(A_STAT, d);
    check("status_drained", d, 32'h2);

    // Ignored writes and zero reads.
    axi_write(A_STAT, 32'h41, 4'hF, 0, 0, r);
    check("w_status_bresp", {30'b0, r}, 32'h0);
    axi_write(A_TX, 32'h41, 4'b1110, 0, 0, r);
    check("w_nostrb_bresp", {30'b0, r}, 32'h0);
    axi_write(32'h1000_000C, 32'h41, 4'hF, 0, 0, r);
    check("w_rsvd_bresp", {30'b0, r}, 32'h0);
    axi_read(A_STAT, d);
    check("status_ignored", d, 32'h2);
    axi_read(A_TX, d);
    check("rd_txdata", d, 32'h0);
    axi_read(32'h1000_0008, d);
    check("rd_rsvd", d, 32'h0);

    // AW leads W by 3 cycles; bready held low 5 cycles.
    axi_write(A_STAT, 32'h0, 4'hF, 3, 5, r);
    check("lead_bresp", {30'b0, r}, 32'h0);

    // Reset in the middle of the DATA phase.
    axi_write(A_TX, 32'h00, 4'hF, 0, 0, r);
    check("w00_bresp", {30'b0, r}, 32'h0);
    repeat (12) @(negedge clk);
    check("pre_rst_tx", {31'b0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'b0, tx}, 32'h1);
    check("rst_mid_valid", {30'b0, bvalid, rvalid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axi_read(A_STAT, d);
    check("status_after_rst", d, 32'h2);
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    check("no_frame_after_rst", {31'b0, bad}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
